fcvt_fp2int: RTL and testbench
==============================

# fcvt_fp2int

Iterative floating-point-to-integer converter for the FPU, implementing FCVT.W/WU/L/LU from single or double precision. It unpacks sign, exponent and mantissa, aligns the significand with a one-bit-per-cycle shifter, rounds per the RISC-V rounding mode, and saturates per the ISA. It sits beside the combinational sign-injection and compare units in the FPU datapath and returns an integer result plus NV/NX flags to integer writeback over a valid/ready handshake.

## Interface
- `BUS_WIDTH`, 64: float operand width. 64 selects double (11-bit exponent, 52-bit mantissa, bias 1023); 32 selects single (8-bit exponent, 23-bit mantissa, bias 127).
- `clk` input 1: clock.
- `rst` input 1: reset, synchronous and active-high.
- `in_valid` input 1: operand valid.
- `in_ready` output 1: high exactly when the FSM is in IDLE.
- `in_op` input BUS_WIDTH: float operand.
- `in_rm` input 3: rounding mode. 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM. Codes 101-111 behave as RTZ; dynamic rounding mode is resolved upstream.
- `in_word` input 1: 1 selects a 32-bit result, sign-extended to 64 bits; 0 selects a 64-bit result.
- `in_unsigned` input 1: 1 selects an unsigned conversion.
- `out_valid` output 1: result valid.
- `out_ready` input 1: consumer accepts the result.
- `out_result` output 64: integer result.
- `out_nv` output 1: invalid flag.
- `out_nx` output 1: inexact flag.

## Operation
- The FSM has four states: IDLE, SHIFT, ROUND, DONE.
- **IDLE:** on `in_valid && in_ready`, capture the operand and all control bits, then classify:
  - Unbiased exponent E = exp − BIAS. Subnormals use E = 1 − BIAS with hidden bit 0.
  - Significand is {hidden, mantissa}.
  - **Direct to DONE (special cases):**
    - NaN → max positive, NV=1.
    - +inf → max, NV=1.
    - −inf → min, NV=1.
    - E ≥ 64 → saturate by sign, NV=1.
    - ±0 → result 0, no flags.
  - **Otherwise, load a shift count and go to SHIFT:**
    - Right count = MANTISSA_SIZE − E, clamped to MANTISSA_SIZE+2.
    - Left count = E − MANTISSA_SIZE.
    - A zero count goes straight to ROUND.
- **SHIFT:** one bit per cycle and count decrements.
  - Right shifts move the outgoing LSB into the guard bit and OR the previous guard into sticky.
  - Left shifts fill with zero.
  - When count reaches 0, go to ROUND.
- **ROUND:** increment the magnitude when the rounding condition holds:
  - RNE: G & (S | LSB).
  - RTZ: never.
  - RDN: sign & (G|S).
  - RUP: !sign & (G|S).
  - RMM: G.
  - NX = G|S.
  - Apply the sign, then range-check against the selected bounds.
  - An out-of-range value yields the saturated result with NV=1 and NX=0.
  - Unsigned with negative sign and nonzero rounded magnitude → result 0, NV=1.
  - Unsigned negative value that rounds to 0 → result 0, NX per G|S.
  - Go to DONE.
- **Saturation bounds:**
  - Signed long: 0x7FFFFFFFFFFFFFFF / 0x8000000000000000.
  - Unsigned long: 0xFFFFFFFFFFFFFFFF / 0.
  - Signed word: 0x000000007FFFFFFF / 0xFFFFFFFF80000000.
  - Unsigned word: 0xFFFFFFFFFFFFFFFF (0xFFFFFFFF sign-extended) / 0.
- **Word-mode results:** always the 32-bit value sign-extended to 64 bits, including WU.
- **DONE:** `out_valid`=1. Result and flags stay stable until `out_ready`; on `out_valid && out_ready`, return to IDLE.

## Timing
- **Reset values:**
  - FSM: IDLE.
  - `in_ready`: 1 in the cycle after reset.
  - `out_valid`, `out_result`, `out_nv`, `out_nx`: 0.
- **Latency**, with acceptance at cycle T and N = shift count:
  - Normal path: `out_valid` first high at T+N+2.
  - Special cases: `out_valid` first high at T+1.
- **Throughput:** one operation at a time. `in_ready`=0 from T+1 until the cycle after the output handshake.
- **Back-to-back:** no input is accepted in the handshake cycle. The next acceptance is possible one cycle later.
- **Reset mid-operation:** aborts, and `out_valid` is never raised for the aborted operation.
- Captured inputs are immune to input changes after acceptance.

## Test plan
- 100.0 double (0x4059000000000000), signed long, RNE, `out_ready`=1:
  - → `out_result`=100, NV=0, NX=0.
  - N=46, so `out_valid` first high at T+48.
- 2.5 double (0x4004000000000000), signed word, across rounding modes:
  - RNE → 2, NX=1.
  - RMM → 3, NX=1.
  - RDN → 2, NX=1.
  - −2.5 with RDN → 0xFFFFFFFFFFFFFFFD, NX=1.
- Specials:
  - qNaN 0x7FF8000000000000, signed word → 0x000000007FFFFFFF, NV=1, at T+1.
  - −inf, unsigned long → 0, NV=1.
- 2^63 (0x43E0000000000000):
  - Signed long → 0x7FFFFFFFFFFFFFFF, NV=1.
  - Unsigned long → 0x8000000000000000, no flags, via a left shift of 11.
- Unsigned negatives:
  - −1.5 unsigned word → 0, NV=1.
  - −0.25 unsigned, RTZ → 0, NX=1, NV=0.
- Backpressure and reset:
  - Hold `out_ready`=0 for 5 cycles → result, flags and `out_valid` stable, `in_ready`=0.
  - Assert `rst` mid-SHIFT → IDLE next cycle, no `out_valid`, and a new operation completes correctly.

Source files
------------

// File: rtl/fcvt_fp2int_if.sv
// fcvt_fp2int_if: operand/result handshake bundle for the
// float-to-integer converter.
interface fcvt_fp2int_if #(
    parameter int BUS_WIDTH = 64
);
    logic                 in_valid;
    logic                 in_ready;
    logic [BUS_WIDTH-1:0] in_op;
    logic [2:0]           in_rm;
    logic                 in_word;
    logic                 in_unsigned;
    logic                 out_valid;
    logic                 out_ready;
    logic [63:0]          out_result;
    logic                 out_nv;
    logic                 out_nx;

    modport slave (
        input  in_valid, in_op, in_rm, in_word, in_unsigned, out_ready,
        output in_ready, out_valid, out_result, out_nv, out_nx
    );

    modport master (
        output in_valid, in_op, in_rm, in_word, in_unsigned, out_ready,
        input  in_ready, out_valid, out_result, out_nv, out_nx
    );
endinterface

// File: rtl/fcvt_fp2int.sv
// fcvt_fp2int: iterative FCVT.W/WU/L/LU from single or double.
// One alignment bit per cycle, RISC-V rounding and saturation.
module fcvt_fp2int #(
    parameter int BUS_WIDTH = 64
) (
    input logic          clk,
    input logic          rst,
    fcvt_fp2int_if.slave bus
);
    localparam int EXP_W  = (BUS_WIDTH == 64) ? 11 : 8;
    localparam int MANT_W = (BUS_WIDTH == 64) ? 52 : 23;
    localparam int BIAS   = (BUS_WIDTH == 64) ? 1023 : 127;
    localparam int CW     = 7;

    typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_e;

    state_e        state_q, state_d;
    logic          sign_q, sign_d, word_q, word_d, uns_q, uns_d;
    logic          left_q, left_d, g_q, g_d, s_q, s_d;
    logic          nv_q, nv_d, nx_q, nx_d;
    logic [2:0]    rm_q, rm_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [63:0]   mag_q, mag_d, res_q, res_d;

    logic [EXP_W-1:0]  exp_f, exp_eff;
    logic [MANT_W-1:0] man_f;
    logic              op_sign, hidden, is_nan, is_inf, is_zero;
    logic signed [13:0] e_s, rdist, ldist;

    assign op_sign = bus.in_op[BUS_WIDTH-1];
    assign exp_f   = bus.in_op[BUS_WIDTH-2 -: EXP_W];
    assign man_f   = bus.in_op[MANT_W-1:0];
    assign hidden  = |exp_f;
    assign is_nan  = (&exp_f) & (|man_f);
    assign is_inf  = (&exp_f) & ~(|man_f);
    assign is_zero = ~hidden & ~(|man_f);
    // subnormals share the exponent of the smallest normal
    assign exp_eff = hidden ? exp_f : EXP_W'(1);
    assign e_s     = $signed(14'(exp_eff)) - $signed(14'(BIAS));
    assign rdist   = $signed(14'(MANT_W)) - e_s;
    assign ldist   = e_s - $signed(14'(MANT_W));

    function automatic logic [63:0] sat(input logic neg, input logic word,
                                        input logic uns);
        logic [63:0] v;
        if (uns)       v = neg ? 64'd0 : '1;
        else if (word) v = neg ? 64'hFFFF_FFFF_8000_0000 : 64'h0000_0000_7FFF_FFFF;
        else           v = neg ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
        return v;
    endfunction

    logic        inc, ovf;
    logic [64:0] rnd, lim;
    logic [63:0] sval, rres;

    always_comb begin
        unique case (rm_q)
            3'b000:  inc = g_q & (s_q | mag_q[0]);
            3'b010:  inc = sign_q & (g_q | s_q);
            3'b011:  inc = ~sign_q & (g_q | s_q);
            3'b100:  inc = g_q;
            default: inc = 1'b0;
        endcase
        rnd = {1'b0, mag_q} + 65'(inc);
        if (uns_q)       lim = word_q ? 65'h0_FFFF_FFFF : 65'h0_FFFF_FFFF_FFFF_FFFF;
        else if (word_q) lim = sign_q ? 65'h0_8000_0000 : 65'h0_7FFF_FFFF;
        else             lim = sign_q ? 65'h0_8000_0000_0000_0000 : 65'h0_7FFF_FFFF_FFFF_FFFF;
        ovf  = (sign_q & uns_q) ? (|rnd) : (rnd > lim);
        sval = sign_q ? -rnd[63:0] : rnd[63:0];
        rres = word_q ? {{32{sval[31]}}, sval[31:0]} : sval;
    end

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        word_d  = word_q;
        uns_d   = uns_q;
        left_d  = left_q;
        g_d     = g_q;
        s_d     = s_q;
        nv_d    = nv_q;
        nx_d    = nx_q;
        rm_d    = rm_q;
        cnt_d   = cnt_q;
        mag_d   = mag_q;
        res_d   = res_q;
        unique case (state_q)
            IDLE: if (bus.in_valid) begin
                sign_d = op_sign;
                word_d = bus.in_word;
                uns_d  = bus.in_unsigned;
                rm_d   = bus.in_rm;
                g_d    = 1'b0;
                s_d    = 1'b0;
                nv_d   = 1'b0;
                nx_d   = 1'b0;
                mag_d  = 64'({hidden, man_f});
                if (is_nan) begin
                    res_d   = sat(1'b0, bus.in_word, bus.in_unsigned);
                    nv_d    = 1'b1;
                    state_d = DONE;
                end else if (is_inf || e_s >= 14'sd64) begin
                    res_d   = sat(op_sign, bus.in_word, bus.in_unsigned);
                    nv_d    = 1'b1;
                    state_d = DONE;
                end else if (is_zero) begin
                    res_d   = '0;
                    state_d = DONE;
                end else if (ldist > 14'sd0) begin
                    left_d  = 1'b1;
                    cnt_d   = CW'(ldist);
                    state_d = SHIFT;
                end else begin
                    left_d  = 1'b0;
                    cnt_d   = (rdist > $signed(14'(MANT_W + 2))) ? CW'(MANT_W + 2) : CW'(rdist);
                    state_d = (rdist == 14'sd0) ? ROUND : SHIFT;
                end
            end
            SHIFT: begin
                cnt_d = cnt_q - CW'(1);
                if (left_q) begin
                    mag_d = mag_q << 1;
                end else begin
                    mag_d = mag_q >> 1;
                    g_d   = mag_q[0];
                    s_d   = s_q | g_q;
                end
                if (cnt_q == CW'(1)) state_d = ROUND;
            end
            ROUND: begin
                res_d   = ovf ? sat(sign_q, word_q, uns_q) : rres;
                nv_d    = ovf;
                nx_d    = ~ovf & (g_q | s_q);
                state_d = DONE;
            end
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            word_q  <= 1'b0;
            uns_q   <= 1'b0;
            left_q  <= 1'b0;
            g_q     <= 1'b0;
            s_q     <= 1'b0;
            nv_q    <= 1'b0;
            nx_q    <= 1'b0;
            rm_q    <= '0;
            cnt_q   <= '0;
            mag_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            word_q  <= word_d;
            uns_q   <= uns_d;
            left_q  <= left_d;
            g_q     <= g_d;
            s_q     <= s_d;
            nv_q    <= nv_d;
            nx_q    <= nx_d;
            rm_q    <= rm_d;
            cnt_q   <= cnt_d;
            mag_q   <= mag_d;
            res_q   <= res_d;
        end
    end

    assign bus.in_ready   = (state_q == IDLE);
    assign bus.out_valid  = (state_q == DONE);
    assign bus.out_result = res_q;
    assign bus.out_nv     = nv_q;
    assign bus.out_nx     = nx_q;
endmodule

// File: tb/tb_fcvt_fp2int.sv
// tb_fcvt_fp2int: directed and random conversions checked against
// a real-arithmetic reference model.
module tb_fcvt_fp2int;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fcvt_fp2int_if #(.BUS_WIDTH(64)) bus ();
    fcvt_fp2int #(.BUS_WIDTH(64)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int n_run  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] fmt(input logic signed [66:0] v, input logic word);
        return word ? {{32{v[31]}}, v[31:0]} : v[63:0];
    endfunction

    // value-level model: exact real arithmetic and integer range checks
    function automatic void ref_model(input logic [63:0] op, input logic [2:0] rm,
                                      input logic word, input logic uns,
                                      output logic [63:0] res, output logic nv,
                                      output logic nx, output int lat);
        logic neg;
        logic [10:0] ef;
        logic [51:0] mf;
        logic signed [66:0] lo, hi, v;
        logic [64:0] m;
        logic inc;
        real a, ip, fr;
        int e;
        neg = op[63];
        ef  = op[62:52];
        mf  = op[51:0];
        if (uns) begin
            lo = 67'sd0;
            hi = word ? 67'sh0_FFFF_FFFF : 67'sh0_FFFF_FFFF_FFFF_FFFF;
        end else if (word) begin
            lo = -67'sh8000_0000;
            hi = 67'sh7FFF_FFFF;
        end else begin
            lo = -67'sh8000_0000_0000_0000;
            hi = 67'sh7FFF_FFFF_FFFF_FFFF;
        end
        e = (ef == 0) ? -1022 : int'(ef) - 1023;
        if (ef == 11'h7FF || (ef == 0 && mf == 0) || e >= 64) lat = 1;
        else if (e > 52) lat = e - 52 + 2;
        else lat = (((52 - e) > 54) ? 54 : (52 - e)) + 2;
        nv = 1'b0;
        nx = 1'b0;
        if (ef == 11'h7FF && mf != 0) begin
            res = fmt(hi, word);
            nv  = 1'b1;
            return;
        end
        if (ef == 11'h7FF) begin
            res = fmt(neg ? lo : hi, word);
            nv  = 1'b1;
            return;
        end
        a  = $bitstoreal({1'b0, op[62:0]});
        ip = $floor(a);
        fr = a - ip;
        if (ip >= 2.0 ** 64) begin
            res = fmt(neg ? lo : hi, word);
            nv  = 1'b1;
            return;
        end
        if (ip >= 2.0 ** 63) m = 65'h0_8000_0000_0000_0000 + 65'(longint'(ip - 2.0 ** 63));
        else m = 65'(longint'(ip));
        case (rm)
            3'd0:    inc = (fr > 0.5) || (fr == 0.5 && m[0]);
            3'd2:    inc = neg && (fr > 0.0);
            3'd3:    inc = !neg && (fr > 0.0);
            3'd4:    inc = (fr >= 0.5);
            default: inc = 1'b0;
        endcase
        m = m + 65'(inc);
        v = neg ? -$signed({2'b00, m}) : $signed({2'b00, m});
        if (v < lo || v > hi) begin
            res = fmt(neg ? lo : hi, word);
            nv  = 1'b1;
        end else begin
            res = fmt(v, word);
            nx  = (fr != 0.0);
        end
    endfunction

    task automatic run_op(input logic [63:0] op, input logic [2:0] rm, input logic word,
                          input logic uns, input int hold, input string tag);
        logic [63:0] er;
        logic env, enx;
        int lat, n;
        ref_model(op, rm, word, uns, er, env, enx, lat);
        @(negedge clk);
        bus.in_valid    = 1'b1;
        bus.in_op       = op;
        bus.in_rm       = rm;
        bus.in_word     = word;
        bus.in_unsigned = uns;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "/acc"}, 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid    = 1'b0;
        bus.in_op       = {$urandom, $urandom};
        bus.in_rm       = 3'($urandom);
        bus.in_word     = ~word;
        bus.in_unsigned = ~uns;
        chk({tag, "/busy"}, 64'(bus.in_ready), 64'd0);
        n = 1;
        while (!bus.out_valid && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "/lat"}, 64'(n), 64'(lat));
        chk({tag, "/res"}, bus.out_result, er);
        chk({tag, "/flags"}, {62'd0, bus.out_nv, bus.out_nx}, {62'd0, env, enx});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk({tag, "/hold"}, {60'd0, bus.out_valid, bus.in_ready, bus.out_nv, bus.out_nx},
                {60'd0, 1'b1, 1'b0, env, enx});
            chk({tag, "/holdres"}, bus.out_result, er);
        end
        @(negedge clk);
        bus.out_ready   = 1'b1;
        bus.in_valid    = 1'b1;
        bus.in_op       = 64'h3FF0_0000_0000_0000;
        @(posedge clk);
        #1;
        bus.in_valid    = 1'b0;
        bus.out_ready   = 1'b0;
        chk({tag, "/hs"}, {62'd0, bus.out_valid, bus.in_ready}, 64'b01);
    endtask

    initial begin
        logic [63:0] op;
        logic [10:0] ex;
        logic [51:0] mt;
        bit seen;
        bus.in_valid    = 1'b0;
        bus.in_op       = '0;
        bus.in_rm       = '0;
        bus.in_word     = 1'b0;
        bus.in_unsigned = 1'b0;
        bus.out_ready   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset/res", bus.out_result, 64'd0);
        chk("reset/ctl", {60'd0, bus.in_ready, bus.out_valid, bus.out_nv, bus.out_nx}, 64'b1000);

        run_op(64'h4059_0000_0000_0000, 3'd0, 1'b0, 1'b0, 0, "100");
        run_op(64'h4004_0000_0000_0000, 3'd0, 1'b1, 1'b0, 5, "2.5rne");
        run_op(64'h4004_0000_0000_0000, 3'd4, 1'b1, 1'b0, 0, "2.5rmm");
        run_op(64'h4004_0000_0000_0000, 3'd2, 1'b1, 1'b0, 0, "2.5rdn");
        run_op(64'hC004_0000_0000_0000, 3'd2, 1'b1, 1'b0, 0, "-2.5rdn");
        run_op(64'h7FF8_0000_0000_0000, 3'd0, 1'b1, 1'b0, 0, "qnan");
        run_op(64'hFFF0_0000_0000_0000, 3'd0, 1'b0, 1'b1, 0, "-inf");
        run_op(64'h43E0_0000_0000_0000, 3'd0, 1'b0, 1'b0, 0, "2^63s");
        run_op(64'h43E0_0000_0000_0000, 3'd0, 1'b0, 1'b1, 0, "2^63u");
        run_op(64'hBFF8_0000_0000_0000, 3'd0, 1'b1, 1'b1, 0, "-1.5uw");
        run_op(64'hBFD0_0000_0000_0000, 3'd1, 1'b0, 1'b1, 0, "-0.25u");
        run_op(64'h8000_0000_0000_0000, 3'd3, 1'b0, 1'b0, 0, "-0");
        run_op(64'h0000_0000_0000_0001, 3'd3, 1'b0, 1'b0, 0, "subn");

        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_op    = 64'h4059_0000_0000_0000;
        bus.in_rm    = 3'd0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst/idle", {62'd0, bus.in_ready, bus.out_valid}, 64'b10);
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen = 1'b1;
        end
        chk("rst/novalid", 64'(seen), 64'd0);
        run_op(64'h4059_0000_0000_0000, 3'd0, 1'b0, 1'b0, 0, "after_rst");

        for (int i = 0; i < 300; i++) begin
            int kind;
            kind = $urandom_range(0, 9);
            mt   = 52'({$urandom, $urandom});
            ex   = 11'(1020 + $urandom_range(0, 70));
            if (kind == 0) op = {$urandom, $urandom};
            else if (kind == 1) op = {1'($urandom), 11'h7FF, ($urandom_range(0, 1) == 1) ? mt : 52'd0};
            else if (kind == 2) op = {1'($urandom), 11'(1023 + $urandom_range(0, 8)),
                                      52'($urandom_range(0, 255)) << 44};
            else op = {1'($urandom), ex, mt};
            run_op(op, 3'($urandom), 1'($urandom), 1'($urandom),
                   $urandom_range(0, 2), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
